// File: rtl/jackpot_n.sv
// jackpot_n: rotating one-hot light game with synchronised switch edges, miss reset, timed win display and saturating score
module jackpot_n #(
    parameter int NUM_LEDS    = 4,
    parameter int DIVISOR     = 200000000,
    parameter int WIN_HOLD    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int SCORE_W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_LEDS-1:0] SWITCHES,
    output logic [NUM_LEDS-1:0] LEDS,
    output logic                win,
    output logic [SCORE_W-1:0]  score
);
    localparam int CW = $clog2(DIVISOR);
    localparam int PW = $clog2(NUM_LEDS);
    localparam int HW = $clog2(WIN_HOLD + 1);
    localparam logic [CW-1:0]       CNT_MAX  = CW'(DIVISOR - 1);
    localparam logic [PW-1:0]       POS_MAX  = PW'(NUM_LEDS - 1);
    localparam logic [HW-1:0]       HOLD_MAX = HW'(WIN_HOLD);
    localparam logic [NUM_LEDS-1:0] ONE      = NUM_LEDS'(1);

    typedef enum logic [1:0] {IDLE, RUN, WIN} state_t;

    state_t                                 r_state, w_state_n;
    logic [CW-1:0]                          r_cnt;
    logic [PW-1:0]                          r_pos, w_pos_n;
    logic [HW-1:0]                          r_hold, w_hold_n;
    logic [SYNC_STAGES-1:0][NUM_LEDS-1:0]   r_sync;
    logic [NUM_LEDS-1:0]                    r_prev, w_rise, w_leds_n;
    logic [SCORE_W-1:0]                     w_score_n;
    logic                                   w_tick, w_win_n;

    assign w_tick = r_cnt == CNT_MAX;
    assign w_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_cnt  <= w_tick ? '0 : r_cnt + CW'(1);
            r_sync <= {r_sync[SYNC_STAGES-2:0], SWITCHES};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    // A rise judged in RUN takes priority over a coincident tick
    always_comb begin
        w_state_n = r_state;
        w_pos_n   = r_pos;
        w_hold_n  = r_hold;
        w_leds_n  = LEDS;
        w_win_n   = 1'b0;
        w_score_n = score;
        case (r_state)
            IDLE: if (w_tick) begin
                w_state_n = RUN;
                w_pos_n   = '0;
                w_leds_n  = ONE;
            end
            RUN: if (w_rise == LEDS) begin
                w_state_n = WIN;
                w_leds_n  = '1;
                w_win_n   = 1'b1;
                w_score_n = (&score) ? score : score + SCORE_W'(1);
                w_hold_n  = '0;
            end else if (w_rise != '0) begin
                w_pos_n  = '0;
                w_leds_n = ONE;
            end else if (w_tick) begin
                w_pos_n  = (r_pos == POS_MAX) ? '0 : r_pos + PW'(1);
                w_leds_n = ONE << w_pos_n;
            end
            WIN: if (w_tick) begin
                w_hold_n = r_hold + HW'(1);
                if (w_hold_n == HOLD_MAX) begin
                    w_state_n = RUN;
                    w_pos_n   = '0;
                    w_leds_n  = ONE;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_pos   <= '0;
            r_hold  <= '0;
            LEDS    <= '0;
            win     <= 1'b0;
            score   <= '0;
        end else begin
            r_state <= w_state_n;
            r_pos   <= w_pos_n;
            r_hold  <= w_hold_n;
            LEDS    <= w_leds_n;
            win     <= w_win_n;
            score   <= w_score_n;
        end
    end
endmodule

// File: tb/tb_jackpot_n.sv
// tb_jackpot_n: directed scoreboard bench for jackpot_n with a 4-clk tick, 2-stage sync and 2-bit score
module tb_jackpot_n;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sw  = '0;
    logic [3:0] leds;
    logic       win;
    logic [1:0] score;

    always #5 clk = ~clk;

    jackpot_n #(.NUM_LEDS(4), .DIVISOR(4), .WIN_HOLD(4), .SYNC_STAGES(2), .SCORE_W(2)) dut (
        .clk(clk), .rst(rst), .SWITCHES(sw), .LEDS(leds), .win(win), .score(score)
    );

    typedef struct {
        string      tag;
        int         k;
        logic [3:0] leds;
        logic       win;
        logic [1:0] score;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   k = 0;
    int   wins = 0;

    always @(posedge clk) if (win === 1'b1) wins <= wins + 1;

    // Drives sw for n clocks; each clock pushes its expectation and pops it once the edge has settled
    task automatic run(input int n, input logic [3:0] s, input logic [3:0] l, input logic w,
                       input logic [1:0] sc, input string tag);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            sw = s;
            k++;
            q.push_back('{tag, k, l, w, sc});
            @(posedge clk);
            #1;
            e = q.pop_front();
            checks++;
            assert (leds === e.leds) else begin
                failures++;
                $error("FAIL %s k=%0d LEDS observed=%b expected=%b", e.tag, e.k, leds, e.leds);
            end
            checks++;
            assert (win === e.win) else begin
                failures++;
                $error("FAIL %s k=%0d win observed=%b expected=%b", e.tag, e.k, win, e.win);
            end
            checks++;
            assert (score === e.score) else begin
                failures++;
                $error("FAIL %s k=%0d score observed=%0d expected=%0d", e.tag, e.k, score, e.score);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        run(3, 4'b0000, 4'b0000, 1'b0, 2'd0, "reset");
        rst = 1'b0;
        k = 0;
        run(3, 4'b0000, 4'b0000, 1'b0, 2'd0, "idle");
        run(4, 4'b0000, 4'b0001, 1'b0, 2'd0, "rot0");
        run(4, 4'b0000, 4'b0010, 1'b0, 2'd0, "rot1");
        run(4, 4'b0000, 4'b0100, 1'b0, 2'd0, "rot2");
        run(4, 4'b0000, 4'b1000, 1'b0, 2'd0, "rot3");
        run(4, 4'b0000, 4'b0001, 1'b0, 2'd0, "rot_wrap");
        run(4, 4'b0000, 4'b0010, 1'b0, 2'd0, "rot1b");
        run(1, 4'b0000, 4'b0100, 1'b0, 2'd0, "rot2b");
        run(2, 4'b0100, 4'b0100, 1'b0, 2'd0, "hit_sync");
        run(1, 4'b0100, 4'b1111, 1'b1, 2'd1, "hit_entry");
        run(8, 4'b0100, 4'b1111, 1'b0, 2'd1, "hit_hold");
        run(4, 4'b0000, 4'b1111, 1'b0, 2'd1, "hit_hold_rel");
        run(4, 4'b0000, 4'b0001, 1'b0, 2'd1, "win_exit");
        run(4, 4'b0000, 4'b0010, 1'b0, 2'd1, "post_win_rot");
        run(2, 4'b0001, 4'b0100, 1'b0, 2'd1, "miss_sync");
        run(2, 4'b0001, 4'b0001, 1'b0, 2'd1, "miss");
        run(2, 4'b0110, 4'b0010, 1'b0, 2'd1, "multi_sync");
        run(2, 4'b0110, 4'b0001, 1'b0, 2'd1, "multi_miss");
        run(4, 4'b0010, 4'b0010, 1'b0, 2'd1, "held_a");
        run(4, 4'b0010, 4'b0100, 1'b0, 2'd1, "held_b");
        run(4, 4'b0010, 4'b1000, 1'b0, 2'd1, "held_c");
        run(4, 4'b0010, 4'b0001, 1'b0, 2'd1, "held_d");
        run(4, 4'b0010, 4'b0010, 1'b0, 2'd1, "held_lit");
        run(1, 4'b0010, 4'b0100, 1'b0, 2'd1, "held_e");
        run(1, 4'b0000, 4'b0100, 1'b0, 2'd1, "release");
        run(2, 4'b0100, 4'b0100, 1'b0, 2'd1, "tick_hit_sync");
        run(1, 4'b0100, 4'b1111, 1'b1, 2'd2, "tick_hit");
        run(5, 4'b0100, 4'b1111, 1'b0, 2'd2, "tick_hold");
        run(10, 4'b0000, 4'b1111, 1'b0, 2'd2, "tick_hold_rel");
        run(2, 4'b0001, 4'b0001, 1'b0, 2'd2, "sat3_sync");
        run(1, 4'b0001, 4'b1111, 1'b1, 2'd3, "sat3");
        run(7, 4'b0001, 4'b1111, 1'b0, 2'd3, "sat3_hold");
        run(6, 4'b0000, 4'b1111, 1'b0, 2'd3, "sat3_rel");
        run(2, 4'b0001, 4'b0001, 1'b0, 2'd3, "sat4_sync");
        run(1, 4'b0001, 4'b1111, 1'b1, 2'd3, "sat4");
        run(7, 4'b0001, 4'b1111, 1'b0, 2'd3, "sat4_hold");
        run(6, 4'b0000, 4'b1111, 1'b0, 2'd3, "sat4_rel");
        run(2, 4'b0001, 4'b0001, 1'b0, 2'd3, "sat5_sync");
        run(1, 4'b0000, 4'b1111, 1'b1, 2'd3, "sat5");
        run(1, 4'b0000, 4'b1111, 1'b0, 2'd3, "sat5_hold");
        checks++;
        assert (wins == 5) else begin
            failures++;
            $error("FAIL win_pulses observed=%0d expected=5", wins);
        end
        rst = 1'b1;
        run(1, 4'b0000, 4'b0000, 1'b0, 2'd0, "rst_in_win");
        rst = 1'b0;
        k = 0;
        run(3, 4'b0000, 4'b0000, 1'b0, 2'd0, "restart_idle");
        run(4, 4'b0000, 4'b0001, 1'b0, 2'd0, "restart_rot0");
        run(1, 4'b0000, 4'b0010, 1'b0, 2'd0, "restart_rot1");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
